// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register bank and its users.
package jk_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t JK_MODE_JK = 2'b00;
    localparam jk_mode_t JK_MODE_UP = 2'b01;
    localparam jk_mode_t JK_MODE_DN = 2'b10;
    localparam jk_mode_t JK_MODE_LD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset to a per-bit value.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // NOTE: state registers use non-blocking assignments so every cell in
    // the bank samples the pre-edge q of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank: per-bit JK, up/down counting via toggle chains,
// and parallel load. Define JKREG_SAT_EN to make the counters saturate.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             changed
);

    jk_mode_t         mode_s;
    logic [WIDTH-1:0] up_carry;
    logic [WIDTH-1:0] dn_carry;
    logic [WIDTH-1:0] eff_j;
    logic [WIDTH-1:0] eff_k;
    logic [WIDTH-1:0] q_next;
    logic             all_ones;
    logic             all_zero;

    assign mode_s   = jk_mode_t'(mode);
    assign all_ones = &q;
    assign all_zero = ~|q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_carry    = '0;
        dn_carry    = '0;
        up_carry[0] = 1'b1;
        dn_carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_carry[i] = up_carry[i-1] & q[i-1];
            dn_carry[i] = dn_carry[i-1] & ~q[i-1];
        end
`ifdef JKREG_SAT_EN
        if (all_ones) up_carry = '0;
        if (all_zero) dn_carry = '0;
`endif
    end

    // NOTE: every signal written here gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        eff_j = '0;
        eff_k = '0;
        case (mode_s)
            JK_MODE_JK: begin eff_j = j;        eff_k = k;        end
            JK_MODE_UP: begin eff_j = up_carry; eff_k = up_carry; end
            JK_MODE_DN: begin eff_j = dn_carry; eff_k = dn_carry; end
            default:    begin eff_j = j;        eff_k = ~j;       end
        endcase
    end

    // Characteristic JK equation, used only to detect a change in q.
    assign q_next = (eff_j & ~q) | (~eff_k & q);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RESET_VAL[i]),
            .en      (en),
            .j       (eff_j[i]),
            .k       (eff_k[i]),
            .q       (q[i]),
            .q_bar   (q_bar[i])
        );
    end

    assign tc = ((mode_s == JK_MODE_UP) && all_ones) ||
                ((mode_s == JK_MODE_DN) && all_zero);

    // NOTE: reset is synchronous, so it lives inside the clocked branch
    // rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed <= 1'b0;
        end else begin
            changed <= en && (q_next != q);
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=8, RESET_VAL=8'hA5).
module tb_jk_reg_bank;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             changed;

    int n_tests = 0;
    int n_fail  = 0;

    jk_reg_bank #(.WIDTH(WIDTH), .RESET_VAL(8'hA5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .q       (q),
        .q_bar   (q_bar),
        .tc      (tc),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m,
                         input logic [WIDTH-1:0] jv, input logic [WIDTH-1:0] kv);
        en = e; mode = m; j = jv; k = kv;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        drive(1'b1, 2'b11, v, 8'h00);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 2'b01, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_q", q, 8'hA5);
        check("rst_qbar", q_bar, 8'h5A);
        check("rst_changed", changed, 1'b0);
        check("rst_tc", tc, 1'b0);

        rst_n = 1'b1;
        tick();
        check("resume_q", q, 8'hA6);
        check("resume_changed", changed, 1'b1);

        load(8'hF0);
        check("load_f0", q, 8'hF0);
        drive(1'b1, 2'b00, 8'h0F, 8'h3C);
        check("jk_tc", tc, 1'b0);
        tick();
        check("jk_q", q, 8'hCF);
        check("jk_qbar", q_bar, 8'h30);
        check("jk_changed", changed, 1'b1);
        drive(1'b1, 2'b00, 8'h00, 8'h00);
        tick();
        check("jk_hold_q", q, 8'hCF);
        check("jk_hold_changed", changed, 1'b0);

        load(8'hFE);
        drive(1'b1, 2'b01, 8'h00, 8'h00);
        check("up_fe_tc", tc, 1'b0);
        tick();
        check("up_ff_q", q, 8'hFF);
        check("up_ff_tc", tc, 1'b1);
        check("up_ff_changed", changed, 1'b1);
        tick();
`ifdef JKREG_SAT_EN
        check("up_sat_q", q, 8'hFF);
        check("up_sat_changed", changed, 1'b0);
        check("up_sat_tc", tc, 1'b1);
        tick();
        check("up_sat2_q", q, 8'hFF);
        check("up_sat2_changed", changed, 1'b0);
`else
        check("up_wrap_q", q, 8'h00);
        check("up_wrap_changed", changed, 1'b1);
        check("up_wrap_tc", tc, 1'b0);
        tick();
        check("up_01_q", q, 8'h01);
`endif

        load(8'h01);
        drive(1'b1, 2'b10, 8'h00, 8'h00);
        check("dn_01_tc", tc, 1'b0);
        tick();
        check("dn_00_q", q, 8'h00);
        check("dn_00_tc", tc, 1'b1);
        mode = 2'b00;
        #1;
        check("jk_mode_zero_tc", tc, 1'b0);
        mode = 2'b10;
        #1;
        tick();
`ifdef JKREG_SAT_EN
        check("dn_sat_q", q, 8'h00);
        check("dn_sat_changed", changed, 1'b0);
`else
        check("dn_wrap_q", q, 8'hFF);
        check("dn_wrap_changed", changed, 1'b1);
        check("dn_wrap_tc", tc, 1'b0);
`endif

        load(8'h3C);
        check("load_3c", q, 8'h3C);
        drive(1'b0, 2'b01, 8'h55, 8'hAA);
        tick();
        check("en0_q", q, 8'h3C);
        check("en0_changed", changed, 1'b0);

        load(8'hFF);
        drive(1'b0, 2'b01, 8'h00, 8'h00);
        #1;
        check("en0_tc_up", tc, 1'b1);
        drive(1'b0, 2'b11, 8'h00, 8'h00);
        #1;
        check("ld_mode_tc", tc, 1'b0);

        load(8'h10);
        drive(1'b1, 2'b01, 8'h00, 8'h00);
        tick();
        check("sw_up", q, 8'h11);
        drive(1'b1, 2'b10, 8'h00, 8'h00);
        tick();
        check("sw_dn", q, 8'h10);
        drive(1'b1, 2'b11, 8'h77, 8'h00);
        tick();
        check("sw_ld", q, 8'h77);
        drive(1'b1, 2'b00, 8'hFF, 8'hFF);
        tick();
        check("sw_jk", q, 8'h88);

        drive(1'b1, 2'b01, 8'h00, 8'h00);
        tick();
        check("pre_rst_q", q, 8'h89);
        rst_n = 1'b0;
        drive(1'b0, 2'b10, 8'h00, 8'h00);
        tick();
        check("midrst_q", q, 8'hA5);
        check("midrst_changed", changed, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 8'h00, 8'h00);
        tick();
        check("post_rst_dn", q, 8'hA4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
